text_write_queue: RTL and testbench

Write-buffering stage between the command register block and the text RAM write port. Captures each single-cycle text cell write (address, attribute/character word, strobe), queues it in a small FIFO, and drains it into text RAM only in cycles where the video renderer grants the port. CPU-side writes therefore never collide with scan-out reads. Out-of-range addresses are filtered, and overflow is reported stickily.

---
 rtl/text_write_queue.sv | 111 +++++++++++
 tb/tb_text_write_queue.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/text_write_queue.sv
// text_write_queue: buffers single-cycle text cell writes from the command
// block and drains them into text RAM only on cycles the renderer grants.
// Out-of-range cell addresses are dropped; lost writes raise a sticky flag.
// Optional build macro TEXT_WQ_COALESCE_EN: a repeat write to the most
// recently queued address overwrites that entry's data instead of allocating.
module text_write_queue #(
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 16,
  parameter int TEXT_CELLS = 2400
) (
  input  logic                     cpu_clock,
  input  logic                     reset_n,
  input  logic                     text_enable,
  input  logic [ADDR_W-1:0]        text_addr,
  input  logic [DATA_W-1:0]        text_data,
  input  logic                     vram_grant,
  input  logic                     clear_overflow,
  output logic                     vram_we,
  output logic [ADDR_W-1:0]        vram_addr,
  output logic [DATA_W-1:0]        vram_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
  localparam logic [LVL_W-1:0]  LVL_ONE   = LVL_W'(1);
  localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(DEPTH);
  // one extra bit so TEXT_CELLS == 2**ADDR_W still compares correctly
  localparam logic [ADDR_W:0]   CELLS_LIM = (ADDR_W+1)'(TEXT_CELLS);

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             valid_wr, push, pop, coalesce;

  assign empty = (level == '0);
  assign full  = (level == LVL_FULL);

`ifdef TEXT_WQ_COALESCE_EN
  logic [PTR_W-1:0] last_ptr;
  assign last_ptr = wr_ptr - PTR_ONE;
`endif

  // Classify this cycle's strobe and grant into push / pop / coalesce
  always_comb begin
    valid_wr = text_enable && ({1'b0, text_addr} < CELLS_LIM);
    pop      = vram_grant && !empty;
    coalesce = 1'b0;
`ifdef TEXT_WQ_COALESCE_EN
    // the newest entry is the head only when level is 1; never edit it mid-pop
    coalesce = valid_wr && !empty && (addr_mem[last_ptr] == text_addr) &&
               !(pop && level == LVL_ONE);
`endif
    // when full, a same-edge pop frees the slot the push lands in
    push     = valid_wr && !coalesce && (!full || pop);
  end

  // Entry storage: no reset needed, pointers/level define what is live
  always_ff @(posedge cpu_clock) begin
    if (push) begin
      addr_mem[wr_ptr] <= text_addr;
      data_mem[wr_ptr] <= text_data;
    end
`ifdef TEXT_WQ_COALESCE_EN
    if (coalesce) data_mem[last_ptr] <= text_data;
`endif
  end

  // Pointers, occupancy and sticky overflow
  always_ff @(posedge cpu_clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
      // set beats a simultaneous clear
      if (valid_wr && !coalesce && !push) overflow <= 1'b1;
      else if (clear_overflow)            overflow <= 1'b0;
    end
  end

  // Registered RAM write port; address/data hold between pops
  always_ff @(posedge cpu_clock or negedge reset_n) begin
    if (!reset_n) begin
      vram_we   <= 1'b0;
      vram_addr <= '0;
      vram_data <= '0;
    end else begin
      vram_we <= pop;
      if (pop) begin
        vram_addr <= addr_mem[rd_ptr];
        vram_data <= data_mem[rd_ptr];
      end
    end
  end

endmodule

// File: tb/tb_text_write_queue.sv
// tb_text_write_queue: directed test-plan sequences plus randomized traffic,
// checked every cycle against a queue-based reference model.
module tb_text_write_queue;

  localparam int DEPTH = 16, ADDR_W = 12, DATA_W = 16, CELLS = 2400;

  logic              cpu_clock = 1'b0;
  logic              reset_n;
  logic              text_enable, vram_grant, clear_overflow;
  logic [ADDR_W-1:0] text_addr;
  logic [DATA_W-1:0] text_data;
  logic              vram_we, empty, full, overflow;
  logic [ADDR_W-1:0] vram_addr;
  logic [DATA_W-1:0] vram_data;
  logic [4:0]        level;

  text_write_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TEXT_CELLS(CELLS)) dut (
    .cpu_clock(cpu_clock), .reset_n(reset_n), .text_enable(text_enable),
    .text_addr(text_addr), .text_data(text_data), .vram_grant(vram_grant),
    .clear_overflow(clear_overflow), .vram_we(vram_we), .vram_addr(vram_addr),
    .vram_data(vram_data), .level(level), .empty(empty), .full(full),
    .overflow(overflow)
  );

  always #5 cpu_clock = ~cpu_clock;

  typedef struct { logic [ADDR_W-1:0] a; logic [DATA_W-1:0] d; } ent_t;
  ent_t              q[$];
  logic              m_ov, m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;
  int                n_vec = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ov = 1'b0; m_we = 1'b0; m_addr = '0; m_data = '0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".we"},    32'(vram_we),   32'(m_we));
    chk({tag, ".addr"},  32'(vram_addr), 32'(m_addr));
    chk({tag, ".data"},  32'(vram_data), 32'(m_data));
    chk({tag, ".level"}, 32'(level),     32'(q.size()));
    chk({tag, ".empty"}, 32'(empty),     32'(q.size() == 0));
    chk({tag, ".full"},  32'(full),      32'(q.size() == DEPTH));
    chk({tag, ".ovf"},   32'(overflow),  32'(m_ov));
  endtask

  // One clock: drive inputs, advance model by the spec rules, compare after edge
  task automatic step(input string tag, input logic en, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d, input logic g, input logic clr);
    bit valid, do_pop, coal, do_push, was_full;
    text_enable = en; text_addr = a; text_data = d; vram_grant = g; clear_overflow = clr;
    @(posedge cpu_clock);
    valid    = en && (int'(a) < CELLS);
    do_pop   = g && (q.size() > 0);
    was_full = (q.size() == DEPTH);
    coal     = 1'b0;
`ifdef TEXT_WQ_COALESCE_EN
    coal = valid && (q.size() > 0) && (q[$].a == a) && !(do_pop && q.size() == 1);
`endif
    do_push = valid && !coal && (!was_full || do_pop);
    if (valid && !coal && !do_push) m_ov = 1'b1;
    else if (clr)                   m_ov = 1'b0;
    m_we = do_pop;
    if (do_pop) begin
      ent_t h;
      h = q.pop_front();
      m_addr = h.a; m_data = h.d;
    end
    if (coal)    q[$].d = d;
    if (do_push) q.push_back('{a: a, d: d});
    #1;
    check_all(tag);
  endtask

  initial begin
    model_reset();
    reset_n = 1'b0; text_enable = 0; text_addr = '0; text_data = '0;
    vram_grant = 0; clear_overflow = 0;
    repeat (2) @(posedge cpu_clock);
    #1;
    check_all("reset");
    reset_n = 1'b1;

    // single write held back until grant
    step("idle", 0, 0, 0, 0, 0);
    step("p5", 1, 12'd5, 16'h4141, 0, 0);
    repeat (3) step("hold", 0, 0, 0, 0, 0);
    chk("hold.lvl1", 32'(level), 32'd1);
    step("grant", 0, 0, 0, 1, 0);
    chk("drain.addr5", 32'(vram_addr), 32'd5);
    chk("drain.data", 32'(vram_data), 32'h4141);
    step("after", 0, 0, 0, 0, 0);
    chk("after.empty", 32'(empty), 32'd1);

    // fill, overflow, full + push + pop
    for (int i = 0; i < DEPTH; i++) step("fill", 1, 12'(i), 16'(16'h100 + i), 0, 0);
    chk("fill.full", 32'(full), 32'd1);
    step("p17", 1, 12'd16, 16'hBEEF, 0, 0);
    chk("p17.ovf", 32'(overflow), 32'd1);
    step("clr", 0, 0, 0, 0, 1);
    step("fullpp", 1, 12'd100, 16'hCAFE, 1, 0);
    chk("fullpp.lvl", 32'(level), 32'd16);
    chk("fullpp.ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < DEPTH + 2; i++) step("drain16", 0, 0, 0, 1, 0);

    // address filter
    step("oor_fff", 1, 12'hFFF, 16'h1, 0, 0);
    step("oor_2400", 1, 12'd2400, 16'h2, 0, 0);
    chk("oor.lvl", 32'(level), 32'd0);
    step("edge_2399", 1, 12'd2399, 16'h3, 0, 0);
    chk("edge.lvl", 32'(level), 32'd1);
    step("edge_drain", 0, 0, 0, 1, 0);
    step("edge_idle", 0, 0, 0, 0, 0);

    // reset while draining
    for (int i = 0; i < 4; i++) step("pre_rst", 1, 12'(40 + i), 16'(i), 0, 0);
    step("rst_drain", 0, 0, 0, 1, 0);
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(posedge cpu_clock);
    #1;
    reset_n = 1'b1;
    repeat (3) step("post_rst", 0, 0, 0, 1, 0);

    // repeated address
    step("c7a", 1, 12'd7, 16'h1111, 0, 0);
    step("c7b", 1, 12'd7, 16'h2222, 0, 0);
`ifdef TEXT_WQ_COALESCE_EN
    chk("coal.lvl", 32'(level), 32'd1);
`else
    chk("coal.lvl", 32'(level), 32'd2);
`endif
    repeat (3) step("c7drain", 0, 0, 0, 1, 0);

    // randomized traffic, grant density alternating to reach full and empty
    for (int c = 0; c < 3000; c++) begin
      int r, gp;
      logic [ADDR_W-1:0] a;
      gp = ((c / 64) % 2) ? 80 : 20;
      r = $urandom_range(0, 9);
      a = (r == 0) ? 12'hFFF : (r == 1) ? 12'd2400 : (r == 2) ? 12'd2399
                   : 12'($urandom_range(0, 7));
      step("rand", ($urandom_range(0, 99) < 60), a, 16'($urandom),
           ($urandom_range(0, 99) < gp), ($urandom_range(0, 99) < 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
